mem_stage: RTL and testbench

// Memory-access pipeline stage between exe_stage and wb_stage. Latches the
// EXE payload, takes data_sram_rdata (sync SRAM, valid the cycle after EXE

---
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: payload latch, SRAM read buffer, load alignment
// Holds first-cycle SRAM data across WB stalls and emits per-byte rf strobes for lwl/lwr.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 71,
   parameter int ES_EX_BUS_WD    = 12,
   parameter int MS_TO_WS_BUS_WD = 74
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [6:0]                 es_load_mem_bus,
   input  logic [ES_EX_BUS_WD-1:0]    es_ex_bus,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       flush,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [ES_EX_BUS_WD-1:0]    ms_ex_bus,
   output logic                       ms_ex,
   output logic                       ms_write_reg,
   output logic [4:0]                 ms_reg_dest,
   output logic [31:0]                ms_to_ds_bus
);

   logic                       ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] ms_payload;
   logic [6:0]                 ms_load;
   logic [ES_EX_BUS_WD-1:0]    ms_ex_r;
   logic                       rbuf_valid;
   logic [31:0]                rbuf;

   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [1:0]  ld_width;
   logic        ld_sign;
   logic [1:0]  ld_lr;
   logic [1:0]  ld_addr;

   assign res_from_mem = ms_payload[70];
   assign gr_we        = ms_payload[69];
   assign dest         = ms_payload[68:64];
   assign alu_result   = ms_payload[63:32];
   assign pc           = ms_payload[31:0];
   assign ld_width     = ms_load[6:5];
   assign ld_sign      = ms_load[4];
   assign ld_lr        = ms_load[3:2];
   assign ld_addr      = ms_load[1:0];

   assign ms_allowin     = !ms_valid || ws_allowin;
   assign ms_to_ws_valid = ms_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   // Payload follows the handshake only; a flushed entry is simply never marked valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_payload <= '0;
         ms_load    <= '0;
         ms_ex_r    <= '0;
      end else if (es_to_ms_valid && ms_allowin) begin
         ms_payload <= es_to_ms_bus;
         ms_load    <= es_load_mem_bus;
         ms_ex_r    <= es_ex_bus;
      end
   end

   // SRAM data is only valid in the first MEM cycle, so capture it when WB stalls us.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rbuf_valid <= 1'b0;
         rbuf       <= '0;
      end else if (flush || ms_allowin) begin
         rbuf_valid <= 1'b0;
      end else if (ms_valid && !ws_allowin && !rbuf_valid && res_from_mem) begin
         rbuf_valid <= 1'b1;
         rbuf       <= data_sram_rdata;
      end
   end

   logic [31:0] raw;
   logic [31:0] shifted;
   logic [15:0] half;
   logic [31:0] load_result;
   logic [3:0]  load_strb;
   logic [31:0] final_result;
   logic [3:0]  rf_wstrb;

   always_comb begin
      raw         = rbuf_valid ? rbuf : data_sram_rdata;
      shifted     = raw >> {ld_addr, 3'b000};
      half        = ld_addr[1] ? raw[31:16] : raw[15:0];
      load_result = raw;
      load_strb   = 4'b1111;
      case (ld_width)
         2'b11: load_result = raw;
         2'b10: load_result = {{16{ld_sign & half[15]}}, half};
         2'b01: load_result = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
         default: begin
            if (ld_lr[1]) begin
               load_result = raw << {~ld_addr, 3'b000};
               load_strb   = 4'b1111 << ~ld_addr;
            end else begin
               load_result = shifted;
               load_strb   = 4'b1111 >> ld_addr;
            end
         end
      endcase
      final_result = res_from_mem ? load_result : alu_result;
      if (!gr_we) begin
         rf_wstrb = 4'b0000;
      end else if (res_from_mem) begin
         rf_wstrb = load_strb;
      end else begin
         rf_wstrb = 4'b1111;
      end
   end

   assign ms_to_ws_bus = {rf_wstrb, gr_we, dest, final_result, pc};
   assign ms_ex_bus    = ms_ex_r;
   // sys | eret | break | ov
   assign ms_ex        = ms_valid && (ms_ex_r[10] || ms_ex_r[7] || ms_ex_r[6] || ms_ex_r[5]);
   assign ms_write_reg = ms_valid && gr_we;
   assign ms_reg_dest  = dest;
   assign ms_to_ds_bus = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [70:0] es_to_ms_bus;
   logic [6:0]  es_load_mem_bus;
   logic [11:0] es_ex_bus;
   logic [31:0] data_sram_rdata;
   logic        flush;
   logic        ms_to_ws_valid;
   logic [73:0] ms_to_ws_bus;
   logic [11:0] ms_ex_bus;
   logic        ms_ex;
   logic        ms_write_reg;
   logic [4:0]  ms_reg_dest;
   logic [31:0] ms_to_ds_bus;

   int checks = 0;
   int failures = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
      .es_load_mem_bus(es_load_mem_bus), .es_ex_bus(es_ex_bus),
      .data_sram_rdata(data_sram_rdata), .flush(flush),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
      .ms_ex_bus(ms_ex_bus), .ms_ex(ms_ex), .ms_write_reg(ms_write_reg),
      .ms_reg_dest(ms_reg_dest), .ms_to_ds_bus(ms_to_ds_bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic res, input logic gr, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [6:0] ld, input logic [11:0] ex);
      es_to_ms_valid  = 1'b1;
      es_to_ms_bus    = {res, gr, dest, alu, pc};
      es_load_mem_bus = ld;
      es_ex_bus       = ex;
   endtask

   // Reference: {strobe, result} computed straight from the load rules.
   function automatic logic [35:0] ref_mem(input logic res, input logic gr,
                                           input logic [31:0] alu, input logic [31:0] raw,
                                           input logic [6:0] ld);
      int a;
      logic [31:0] r;
      logic [3:0] s;
      a = int'(ld[1:0]);
      s = 4'hf;
      if (!res) begin
         r = alu;
      end else begin
         case (ld[6:5])
            2'd3: r = raw;
            2'd2: begin
               r = (raw >> (16 * (a / 2))) & 32'hffff;
               if (ld[4] && r >= 32'h8000) r = r - 32'h10000;
            end
            2'd1: begin
               r = (raw >> (8 * a)) & 32'hff;
               if (ld[4] && r >= 32'h80) r = r - 32'h100;
            end
            default: begin
               if (ld[3]) begin
                  r = raw << (8 * (3 - a));
                  s = (a == 0) ? 4'b1000 : (a == 1) ? 4'b1100 : (a == 2) ? 4'b1110 : 4'b1111;
               end else begin
                  r = raw >> (8 * a);
                  s = (a == 0) ? 4'b1111 : (a == 1) ? 4'b0111 : (a == 2) ? 4'b0011 : 4'b0001;
               end
            end
         endcase
      end
      if (!gr) s = 4'b0000;
      return {s, r};
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      es_load_mem_bus = '0; es_ex_bus = '0; data_sram_rdata = '0; flush = 1'b0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); end
      checks++; if (ms_to_ws_bus !== 74'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", ms_to_ws_bus); end
      checks++; if ({ms_ex, ms_write_reg} !== 2'b00) begin failures++; $display("FAIL reset_ex_wr got=%b exp=00", {ms_ex, ms_write_reg}); end
      checks++; if ({ms_ex_bus, ms_to_ds_bus, ms_reg_dest} !== 49'd0) begin failures++; $display("FAIL reset_side_buses got=%h exp=0", {ms_ex_bus, ms_to_ds_bus, ms_reg_dest}); end
      checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
   endtask

   task automatic test_byte;
      logic [31:0] exp_res [2];
      exp_res[0] = 32'h0000_0080;
      exp_res[1] = 32'hFFFF_FF80;
      for (int sg = 1; sg >= 0; sg--) begin
         @(posedge clk); #1;
         ws_allowin = 1'b1;
         send(1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'hBFC0_0100, {2'b01, sg[0], 2'b00, 2'b11}, 12'd0);
         tick();
         es_to_ms_valid = 1'b0;
         data_sram_rdata = 32'h80FF_1234;
         @(negedge clk);
         checks++; if (ms_to_ws_bus[63:32] !== exp_res[sg]) begin failures++; $display("FAIL byte_result sign=%0d got=%h exp=%h", sg, ms_to_ws_bus[63:32], exp_res[sg]); end
         checks++; if (ms_to_ws_bus[73:70] !== 4'b1111) begin failures++; $display("FAIL byte_strb got=%b exp=1111", ms_to_ws_bus[73:70]); end
      end
   endtask

   task automatic test_lwl_lwr;
      @(posedge clk); #1;
      send(1'b1, 1'b1, 5'd8, 32'h0, 32'h4, {2'b00, 1'b0, 2'b10, 2'b01}, 12'd0);
      tick();
      send(1'b1, 1'b1, 5'd8, 32'h0, 32'h8, {2'b00, 1'b0, 2'b01, 2'b10}, 12'd0);
      data_sram_rdata = 32'hAABB_CCDD;
      @(negedge clk);
      checks++; if (ms_to_ws_bus[73:32] !== {4'b1100, 1'b1, 5'd8, 32'hCCDD_0000}) begin failures++; $display("FAIL lwl got=%h exp=%h", ms_to_ws_bus[73:32], {4'b1100, 1'b1, 5'd8, 32'hCCDD_0000}); end
      tick();
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      checks++; if (ms_to_ws_bus[73:32] !== {4'b0011, 1'b1, 5'd8, 32'h0000_AABB}) begin failures++; $display("FAIL lwr got=%h exp=%h", ms_to_ws_bus[73:32], {4'b0011, 1'b1, 5'd8, 32'h0000_AABB}); end
   endtask

   task automatic test_stall_hold;
      @(posedge clk); #1;
      ws_allowin = 1'b1;
      send(1'b1, 1'b1, 5'd9, 32'h0, 32'h10, {2'b10, 1'b1, 2'b00, 2'b10}, 12'd0);
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      data_sram_rdata = 32'h8001_7FFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if ({ms_to_ws_valid, ms_allowin, ms_to_ds_bus} !== {2'b10, 32'hFFFF_8001}) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", c, {ms_to_ws_valid, ms_allowin, ms_to_ds_bus}, {2'b10, 32'hFFFF_8001}); end
         tick();
         data_sram_rdata = 32'h0;
      end
      ws_allowin = 1'b1;
      @(negedge clk);
      checks++; if ({ms_to_ws_valid, ms_to_ws_bus[63:32]} !== {1'b1, 32'hFFFF_8001}) begin failures++; $display("FAIL stall_release got=%h exp=%h", {ms_to_ws_valid, ms_to_ws_bus[63:32]}, {1'b1, 32'hFFFF_8001}); end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [31:0] alu_q [$];
      logic [31:0] pc_q [$];
      logic        gr_q [$];
      logic [31:0] a, p;
      logic g;
      ws_allowin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) begin
            a = $urandom; p = $urandom; g = 1'($urandom);
            send(1'b0, g, 5'(i + 1), a, p, 7'd0, 12'd0);
            alu_q.push_back(a); pc_q.push_back(p); gr_q.push_back(g);
         end else begin
            es_to_ms_valid = 1'b0;
         end
         if (i > 0) begin
            a = alu_q.pop_front(); p = pc_q.pop_front(); g = gr_q.pop_front();
            @(negedge clk);
            checks++; if ({ms_to_ws_valid, ms_to_ws_bus} !== {1'b1, {4{g}}, g, 5'(i), a, p}) begin failures++; $display("FAIL b2b_bus i=%0d got=%h exp=%h", i, {ms_to_ws_valid, ms_to_ws_bus}, {1'b1, {4{g}}, g, 5'(i), a, p}); end
            checks++; if (ms_write_reg !== g) begin failures++; $display("FAIL b2b_write_reg i=%0d got=%b exp=%b", i, ms_write_reg, g); end
         end
         tick();
      end
   endtask

   task automatic test_flush;
      ws_allowin = 1'b1;
      send(1'b1, 1'b1, 5'd4, 32'h0, 32'h20, {2'b11, 1'b0, 2'b00, 2'b00}, 12'h400);
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      data_sram_rdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (ms_ex !== 1'b1) begin failures++; $display("FAIL flush_pre_ex got=%b exp=1", ms_ex); end
      tick();
      flush = 1'b1;
      es_to_ms_valid = 1'b1;
      tick();
      flush = 1'b0;
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      checks++; if ({ms_to_ws_valid, dut.rbuf_valid, ms_ex} !== 3'b000) begin failures++; $display("FAIL flush_stalled got=%b exp=000", {ms_to_ws_valid, dut.rbuf_valid, ms_ex}); end
      @(posedge clk); #1;
      ws_allowin = 1'b1;
      send(1'b0, 1'b1, 5'd21, 32'h55, 32'h24, 7'd0, 12'h020);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      checks++; if ({ms_to_ws_valid, ms_write_reg, ms_ex, ms_reg_dest} !== {3'b000, 5'd21}) begin failures++; $display("FAIL flush_same_cycle got=%h exp=%h", {ms_to_ws_valid, ms_write_reg, ms_ex, ms_reg_dest}, {3'b000, 5'd21}); end
   endtask

   task automatic test_async_reset;
      @(posedge clk); #1;
      ws_allowin = 1'b1;
      send(1'b1, 1'b1, 5'd6, 32'h0, 32'h30, {2'b11, 1'b0, 2'b00, 2'b00}, 12'h020);
      tick();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      @(negedge clk);
      checks++; if ({ms_to_ws_valid, ms_ex} !== 2'b11) begin failures++; $display("FAIL areset_pre got=%b exp=11", {ms_to_ws_valid, ms_ex}); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({ms_to_ws_valid, ms_ex} !== 2'b00) begin failures++; $display("FAIL areset_drop got=%b exp=00", {ms_to_ws_valid, ms_ex}); end
      tick();
      reset = 1'b0;
      ws_allowin = 1'b1;
   endtask

   task automatic test_random;
      logic        mv = 1'b0, m_res = 1'b0, m_gr = 1'b0, entered = 1'b0;
      logic [4:0]  m_dest = '0;
      logic [31:0] m_alu = '0, m_pc = '0, m_data = '0;
      logic [6:0]  m_ld = '0;
      logic [11:0] m_ex = '0;
      logic        nv, ws, fl, allow;
      logic [1:0]  w, lr;
      logic [35:0] e;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         data_sram_rdata = entered ? m_data : $urandom;
         nv = ($urandom % 3) != 0;
         ws = ($urandom % 4) != 0;
         fl = ($urandom % 16) == 0;
         w  = 2'($urandom);
         lr = (w != 2'b00) ? 2'b00 : (($urandom % 2) != 0 ? 2'b10 : 2'b01);
         send(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
              {w, 1'($urandom), lr, 2'($urandom)}, 12'($urandom));
         es_to_ms_valid = nv;
         ws_allowin = ws;
         flush = fl;
         @(negedge clk);
         checks++; if (ms_allowin !== (!mv || ws)) begin failures++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, ms_allowin, !mv || ws); end
         checks++; if ({ms_to_ws_valid, ms_write_reg, ms_ex} !== {mv, mv & m_gr, mv & (m_ex[10] | m_ex[7] | m_ex[6] | m_ex[5])}) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {ms_to_ws_valid, ms_write_reg, ms_ex}, {mv, mv & m_gr, mv & (m_ex[10] | m_ex[7] | m_ex[6] | m_ex[5])}); end
         checks++; if ({ms_ex_bus, ms_reg_dest} !== {m_ex, m_dest}) begin failures++; $display("FAIL rnd_side cyc=%0d got=%h exp=%h", cyc, {ms_ex_bus, ms_reg_dest}, {m_ex, m_dest}); end
         if (mv) begin
            e = ref_mem(m_res, m_gr, m_alu, m_data, m_ld);
            checks++; if ({ms_to_ws_bus, ms_to_ds_bus} !== {e[35:32], m_gr, m_dest, e[31:0], m_pc, e[31:0]}) begin failures++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", cyc, {ms_to_ws_bus, ms_to_ds_bus}, {e[35:32], m_gr, m_dest, e[31:0], m_pc, e[31:0]}); end
         end
         @(posedge clk); #1;
         allow = !mv || ws;
         entered = nv && allow;
         if (entered) begin
            {m_res, m_gr, m_dest, m_alu, m_pc} = es_to_ms_bus;
            m_ld = es_load_mem_bus;
            m_ex = es_ex_bus;
            m_data = $urandom;
         end
         mv = fl ? 1'b0 : (allow ? nv : mv);
      end
      es_to_ms_valid = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_byte();
      test_lwl_lwr();
      test_stall_hold();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
